// File: rtl/dec_stage.sv
// -----------------------------------------------------------------------------
// dec_stage : decode stage of the 5-stage RV32I pipeline.
//
// Takes the IF/ID register contents from fetch (pc, pc+4, valid) and the imem
// read data. It decodes control fields and the immediate, and registers them
// into ID/EX. It also detects load-use hazards and asks fetch to hold.
//
// Optional feature: define DEC_ILLEGAL_EN to flag opcodes outside the RV32I
// base set, and SYSTEM with funct3!=0, as illegal. Otherwise o_illegal is
// tied 0 and unknown opcodes decode as NOP.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_inst, i_vld           IF/ID instruction word and valid
//   i_pc, i_nxt_pc          IF/ID pc and pc+4
//   i_flush                 redirect from fetch: kill the instruction in ID
//   o_hold                  load-use stall request to fetch (combinational)
//   o_rs1_addr, o_rs2_addr  register file read indices (combinational)
//   o_vld..o_illegal        ID/EX register contents
//   o_dbg_state             FSM state (0 = RUN, 1 = STALL)
//
// Handshake: there is no backpressure from EX. On each edge ID/EX loads either
// the decoded IF/ID instruction or a bubble. When o_hold is high, fetch must
// keep IF/ID unchanged for the next cycle.
// -----------------------------------------------------------------------------
module dec_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_inst,
  input  logic        i_vld,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  input  logic        i_flush,
  output logic        o_hold,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic        o_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic [31:0] o_inst,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_imm,
  output logic [2:0]  o_opsel,
  output logic        o_branch,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic        o_reg_wr,
  output logic        o_halt,
  output logic        o_illegal,
  output logic        o_dbg_state
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_e;
  state_e state;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic        is_load, is_store, is_opimm, is_op, is_fence, is_system;
  logic        illegal_d, reg_wr_d, halt_d;
  logic        rs1_used, rs2_used, haz, issue;
  logic [31:0] imm_d;

  assign opcode     = i_inst[6:0];
  assign funct3     = i_inst[14:12];
  assign rd         = i_inst[11:7];
  assign o_rs1_addr = i_inst[19:15];
  assign o_rs2_addr = i_inst[24:20];

  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_opimm  = (opcode == OP_OPIMM);
  assign is_op     = (opcode == OP_OP);
  assign is_fence  = (opcode == OP_FENCE);
  assign is_system = (opcode == OP_SYSTEM);

`ifdef DEC_ILLEGAL_EN
  assign illegal_d = ~(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                       is_store | is_opimm | is_op | is_fence | is_system) |
                     (is_system & (funct3 != 3'd0));
`else
  assign illegal_d = 1'b0;
`endif

  assign reg_wr_d = (is_op | is_opimm | is_load | is_lui | is_auipc | is_jal | is_jalr) &
                    (rd != 5'd0);
  assign halt_d   = is_system & (funct3 == 3'd0);

  // The immediate is selected by opcode; every other format, including
  // R-type, SYSTEM and FENCE, carries zero.
  always_comb begin
    imm_d = '0;
    case (opcode)
      OP_OPIMM, OP_LOAD, OP_JALR: imm_d = {{20{i_inst[31]}}, i_inst[31:20]};
      OP_STORE:  imm_d = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      OP_BRANCH: imm_d = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                          i_inst[11:8], 1'b0};
      OP_JAL:    imm_d = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                          i_inst[30:21], 1'b0};
      OP_LUI, OP_AUIPC: imm_d = {i_inst[31:12], 12'h000};
      default:   imm_d = '0;
    endcase
  end

  // Load-use hazard against the load sitting in ID/EX. Illegal instructions
  // never stall (illegal_d is constant 0 when the feature is off).
  assign rs1_used = ~(is_lui | is_auipc | is_jal);
  assign rs2_used = is_op | is_store | is_branch;
  assign haz = i_vld & o_vld & o_mem_rd & (o_rd_addr != 5'd0) & ~illegal_d &
               ((rs1_used & (o_rs1_addr == o_rd_addr)) |
                (rs2_used & (o_rs2_addr == o_rd_addr)));

  assign o_hold = haz & ~i_flush;

  // Flush and hazard both suppress issue; the stalled instruction is re-offered
  // by fetch next cycle, when o_vld=0 guarantees haz is false.
  assign issue = i_vld & ~i_flush & ~haz;

  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_RUN;
      o_vld     <= 1'b0;
      o_pc      <= '0;
      o_nxt_pc  <= '0;
      o_inst    <= NOP_INST;
      o_rd_addr <= '0;
      o_imm     <= '0;
      o_opsel   <= '0;
      o_branch  <= 1'b0;
      o_jal     <= 1'b0;
      o_jalr    <= 1'b0;
      o_mem_rd  <= 1'b0;
      o_mem_wr  <= 1'b0;
      o_reg_wr  <= 1'b0;
      o_halt    <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      case (state)
        ST_RUN:   state <= (haz & ~i_flush) ? ST_STALL : ST_RUN;
        ST_STALL: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase

      if (issue) begin
        o_vld     <= 1'b1;
        o_pc      <= i_pc;
        o_nxt_pc  <= i_nxt_pc;
        o_inst    <= i_inst;
        o_rd_addr <= rd;
        o_imm     <= illegal_d ? 32'd0 : imm_d;
        o_opsel   <= funct3;
        o_branch  <= is_branch;
        o_jal     <= is_jal;
        o_jalr    <= is_jalr;
        o_mem_rd  <= is_load;
        o_mem_wr  <= is_store;
        o_reg_wr  <= reg_wr_d;
        o_halt    <= halt_d;
        o_illegal <= illegal_d;
      end else begin
        // Bubble: pc/imm/rd/opsel keep their old values so they stay stable.
        o_vld     <= 1'b0;
        o_inst    <= NOP_INST;
        o_branch  <= 1'b0;
        o_jal     <= 1'b0;
        o_jalr    <= 1'b0;
        o_mem_rd  <= 1'b0;
        o_mem_wr  <= 1'b0;
        o_reg_wr  <= 1'b0;
        o_halt    <= 1'b0;
        o_illegal <= 1'b0;
      end
    end
  end

endmodule
